// File: rtl/mult_booth_seq.sv
// Sequential radix-2 Booth multiplier. Runs WIDTH+1 iterations on signed or unsigned operands.
// The full 2*WIDTH-bit product appears on hi/lo, with a busy/done handshake.
module mult_booth_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned N  = WIDTH + 1;
  localparam int unsigned PW = 2 * WIDTH + 3;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    p_q, p_d;
  logic [WIDTH:0]   a_ext_q, a_ext_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             accept;
  logic             last;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   b_ext;
  logic [WIDTH:0]   upper;
  logic [WIDTH:0]   sum;
  logic [PW-1:0]    p_shift;

  assign accept = (state_q == StIdle) && start;
  assign last   = (cnt_q == CW'(1));

  // One extra operand bit lets unsigned operands go through the signed Booth recoding.
  assign a_ext  = {signed_mode & a[WIDTH-1], a};
  assign b_ext  = {signed_mode & b[WIDTH-1], b};
  assign upper  = p_q[PW-1:WIDTH+2];

  always_comb begin
    sum = upper;
    case (p_q[1:0])
      2'b01:   sum = upper + a_ext_q;
      2'b10:   sum = upper - a_ext_q;
      default: sum = upper;
    endcase
  end

  // Arithmetic right shift: the new MSB replicates the sign of the updated upper field.
  assign p_shift = {sum[WIDTH], sum, p_q[WIDTH+1:1]};

  // State register
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= StIdle;
      p_q     <= '0;
      a_ext_q <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      a_ext_q <= a_ext_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    a_ext_d = a_ext_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StRun;
          a_ext_d = a_ext;
          p_d     = {{(WIDTH + 1){1'b0}}, b_ext, 1'b0};
          cnt_d   = CW'(N);
        end
      end
      StRun: begin
        p_d   = p_shift;
        cnt_d = cnt_q - CW'(1);
        if (last) begin
          state_d        = StIdle;
          {hi_d, lo_d}   = p_shift[2*WIDTH:1];
          done_d         = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q == StRun);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule

// File: tb/tb_mult_booth_seq.sv
// Self-checking bench for mult_booth_seq at WIDTH=32 and WIDTH=8.
// Expected products come from plain integer multiplication.
module tb_mult_booth_seq;

  logic        clk = 1'b0;
  logic        Reset;

  logic [31:0] a32, b32, hi32, lo32;
  logic        sm32, start32, busy32, done32;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        sm8, start8, busy8, done8;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  mult_booth_seq #(.WIDTH(32)) dut32 (
    .clk        (clk),
    .Reset      (Reset),
    .a          (a32),
    .b          (b32),
    .signed_mode(sm32),
    .start      (start32),
    .busy       (busy32),
    .done       (done32),
    .hi         (hi32),
    .lo         (lo32)
  );

  mult_booth_seq #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .Reset      (Reset),
    .a          (a8),
    .b          (b8),
    .signed_mode(sm8),
    .start      (start8),
    .busy       (busy8),
    .done       (done8),
    .hi         (hi8),
    .lo         (lo8)
  );

  function automatic logic [63:0] ref32(input logic [31:0] x, input logic [31:0] y,
                                        input logic sm);
    longint px;
    if (sm) px = longint'($signed(x)) * longint'($signed(y));
    else    px = longint'({32'b0, x}) * longint'({32'b0, y});
    return px;
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y,
                                       input logic sm);
    int px;
    if (sm) px = int'($signed(x)) * int'($signed(y));
    else    px = int'({24'b0, x}) * int'({24'b0, y});
    return px[15:0];
  endfunction

  // Starts one operation and waits for done; lat=-1 when done never arrives.
  task automatic op32(input logic [31:0] x, input logic [31:0] y, input logic sm,
                      output int lat, output bit busy_ok, output time tdone);
    lat = -1;
    busy_ok = 1'b1;
    tdone = 0;
    @(negedge clk);
    a32 = x; b32 = y; sm32 = sm; start32 = 1'b1;
    @(posedge clk);
    #1;
    if (!busy32) busy_ok = 1'b0;
    @(negedge clk);
    start32 = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (done32) begin
        lat = k;
        tdone = $time;
        break;
      end
      if (!busy32) busy_ok = 1'b0;
    end
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic sm,
                     output int lat);
    lat = -1;
    @(negedge clk);
    a8 = x; b8 = y; sm8 = sm; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (done8) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy32, done32, hi32, lo32} !== 66'b0) begin
      errors++;
      $display("FAIL reset32: got busy=%b done=%b hi=%h lo=%h, want all zero",
               busy32, done32, hi32, lo32);
    end
    vectors++;
    if ({busy8, done8, hi8, lo8} !== 18'b0) begin
      errors++;
      $display("FAIL reset8: got busy=%b done=%b hi=%h lo=%h, want all zero",
               busy8, done8, hi8, lo8);
    end
    Reset = 1'b0;
  endtask

  // Single operation with fixed operands: result, latency 33 and busy throughout.
  task automatic check32(input string name, input logic [31:0] x, input logic [31:0] y,
                         input logic sm, input logic [63:0] want);
    int lat; bit bok; time td;
    op32(x, y, sm, lat, bok, td);
    vectors++;
    if ({hi32, lo32} !== want || {hi32, lo32} !== ref32(x, y, sm)) begin
      errors++;
      $display("FAIL %s: got %h_%h want %h", name, hi32, lo32, want);
    end
    vectors++;
    if (lat != 33 || !bok || busy32 !== 1'b0) begin
      errors++;
      $display("FAIL %s_timing: got lat=%0d busy_ok=%0d busy_at_done=%b want 33/1/0",
               name, lat, bok, busy32);
    end
  endtask

  task automatic test_fixed32();
    check32("signed_small", 32'd7, 32'hFFFFFFFD, 1'b1, 64'hFFFFFFFF_FFFFFFEB);
    check32("unsigned_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001);
    check32("signed_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001);
    check32("min_min", 32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000);
    check32("min_one", 32'h80000000, 32'd1, 1'b1, 64'hFFFFFFFF_80000000);
  endtask

  task automatic test_random32();
    int lat; bit bok; time td;
    logic [31:0] x, y; logic sm;
    for (int i = 0; i < 20; i++) begin
      x = $urandom; y = $urandom; sm = 1'($urandom_range(0, 1));
      op32(x, y, sm, lat, bok, td);
      vectors++;
      if ({hi32, lo32} !== ref32(x, y, sm) || lat != 33) begin
        errors++;
        $display("FAIL rand32: a=%h b=%h sm=%b got %h_%h lat=%0d want %h lat=33",
                 x, y, sm, hi32, lo32, lat, ref32(x, y, sm));
      end
    end
  endtask

  // start stays high and operands churn during RUN; only the latched values count.
  task automatic test_start_held();
    logic [31:0] x, y;
    int dones, lat;
    x = $urandom; y = $urandom;
    dones = 0; lat = -1;
    @(negedge clk);
    a32 = x; b32 = y; sm32 = 1'b1; start32 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      a32 = $urandom; b32 = $urandom; sm32 = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      if (done32) begin
        dones++;
        lat = k;
        break;
      end
    end
    @(negedge clk);
    start32 = 1'b0;
    vectors++;
    if ({hi32, lo32} !== ref32(x, y, 1'b1) || lat != 33) begin
      errors++;
      $display("FAIL start_held: got %h_%h lat=%0d want %h lat=33",
               hi32, lo32, lat, ref32(x, y, 1'b1));
    end
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done32) dones++;
    end
    vectors++;
    if (dones != 1 || busy32 !== 1'b0) begin
      errors++;
      $display("FAIL start_held_dones: got dones=%0d busy=%b want 1/0", dones, busy32);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2; bit b1, b2; time t1, t2;
    logic [31:0] x1, y1, x2, y2;
    logic [63:0] r1;
    x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom;
    op32(x1, y1, 1'b0, lat1, b1, t1);
    r1 = {hi32, lo32};
    // op32 returns inside the done cycle, so this start lands while done is high.
    op32(x2, y2, 1'b1, lat2, b2, t2);
    vectors++;
    if (r1 !== ref32(x1, y1, 1'b0) || {hi32, lo32} !== ref32(x2, y2, 1'b1)) begin
      errors++;
      $display("FAIL b2b_results: got %h / %h_%h want %h / %h",
               r1, hi32, lo32, ref32(x1, y1, 1'b0), ref32(x2, y2, 1'b1));
    end
    vectors++;
    if (lat1 != 33 || lat2 != 33 || (t2 - t1) != 340) begin
      errors++;
      $display("FAIL b2b_gap: got lat=%0d/%0d gap=%0t want 33/33 gap=340",
               lat1, lat2, t2 - t1);
    end
  endtask

  task automatic test_reset_mid_run();
    int dones, lat; bit bok; time td;
    @(negedge clk);
    a32 = $urandom; b32 = $urandom; sm32 = 1'b1; start32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    repeat (9) @(negedge clk);
    Reset = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({busy32, done32, hi32, lo32} !== 66'b0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h want all zero",
               busy32, done32, hi32, lo32);
    end
    @(negedge clk);
    Reset = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done32 || busy32) dones++;
    end
    vectors++;
    if (dones != 0) begin
      errors++;
      $display("FAIL reset_mid_nodone: got %0d active cycles want 0", dones);
    end
    op32(32'd5, 32'd6, 1'b0, lat, bok, td);
    vectors++;
    if (hi32 !== 32'd0 || lo32 !== 32'd30 || lat != 33) begin
      errors++;
      $display("FAIL after_reset: got %h_%h lat=%0d want 0_1e lat=33", hi32, lo32, lat);
    end
  endtask

  task automatic test_w8();
    int lat, badlat;
    logic [7:0] x, y; logic sm;
    op8(8'h80, 8'h80, 1'b1, lat);
    vectors++;
    if (hi8 !== 8'h40 || lo8 !== 8'h00 || lat != 9) begin
      errors++;
      $display("FAIL w8_min_min: got %h_%h lat=%0d want 40_00 lat=9", hi8, lo8, lat);
    end
    badlat = 0;
    for (int i = 0; i < 1000; i++) begin
      x = 8'($urandom); y = 8'($urandom); sm = 1'($urandom_range(0, 1));
      op8(x, y, sm, lat);
      if (lat != 9) badlat++;
      vectors++;
      if ({hi8, lo8} !== ref8(x, y, sm)) begin
        errors++;
        $display("FAIL w8_rand: a=%h b=%h sm=%b got %h_%h want %h",
                 x, y, sm, hi8, lo8, ref8(x, y, sm));
      end
    end
    vectors++;
    if (badlat != 0) begin
      errors++;
      $display("FAIL w8_latency: got %0d vectors with latency other than 9, want 0", badlat);
    end
  endtask

  initial begin
    Reset = 1'b1;
    a32 = '0; b32 = '0; sm32 = 1'b0; start32 = 1'b0;
    a8 = '0; b8 = '0; sm8 = 1'b0; start8 = 1'b0;
    test_reset();
    test_fixed32();
    test_random32();
    test_start_held();
    test_back_to_back();
    test_reset_mid_run();
    test_w8();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
